// File: rtl/elevator_car.sv
// Elevator car: runs one UP/DOWN/SERVE command at a time with timed travel and door cycles.
// Optional `ELEV_CAR_DOOR_REOPEN_EN: door_block holds the doors open while asserted.
module elevator_car #(
  parameter int N_FLOORS      = 4,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 6,
  localparam int F_BITS       = $clog2(N_FLOORS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cmd,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              door_block,
  output logic [F_BITS-1:0] cur_floor,
  output logic              moving,
  output logic              doors_open,
  output logic              done,
  output logic              fault
);

  localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0]     TRAVEL_LOAD = CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0]     DOOR_LOAD   = CW'(DOOR_CYCLES - 1);
  localparam logic [F_BITS-1:0] TOP_FLOOR   = F_BITS'(N_FLOORS - 1);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR, S_FIN} state_e;
  typedef enum logic [1:0] {C_IDLE, C_UP, C_DOWN, C_SERVE} cmd_e;

  state_e            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [F_BITS-1:0] r_floor, w_floor_nxt;
  logic              r_dir_up, w_dir_up_nxt;
  logic              w_fault_nxt;
  logic              w_reload;
  logic              r_moving, r_doors_open, r_done, r_fault;

`ifdef ELEV_CAR_DOOR_REOPEN_EN
  assign w_reload = door_block;
`else
  logic w_unused_door_block;
  assign w_unused_door_block = door_block;
  assign w_reload            = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_floor_nxt  = r_floor;
    w_dir_up_nxt = r_dir_up;
    w_fault_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd)
            C_UP: begin
              w_dir_up_nxt = 1'b1;
              if (r_floor != TOP_FLOOR) begin
                w_state_nxt = S_MOVE;
                w_cnt_nxt   = TRAVEL_LOAD;
              end else begin
                w_state_nxt = S_FIN;
                w_fault_nxt = 1'b1;
              end
            end
            C_DOWN: begin
              w_dir_up_nxt = 1'b0;
              if (r_floor != '0) begin
                w_state_nxt = S_MOVE;
                w_cnt_nxt   = TRAVEL_LOAD;
              end else begin
                w_state_nxt = S_FIN;
                w_fault_nxt = 1'b1;
              end
            end
            C_SERVE: begin
              w_state_nxt = S_DOOR;
              w_cnt_nxt   = DOOR_LOAD;
            end
            default: w_state_nxt = S_FIN;
          endcase
        end
      end
      S_MOVE: begin
        if (r_cnt == '0) begin
          // Moves past the end floors were rejected at accept, so no wrap is possible.
          w_floor_nxt = r_dir_up ? r_floor + F_BITS'(1) : r_floor - F_BITS'(1);
          w_state_nxt = S_FIN;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_DOOR: begin
        if (w_reload)          w_cnt_nxt   = DOOR_LOAD;
        else if (r_cnt == '0)  w_state_nxt = S_FIN;
        else                   w_cnt_nxt   = r_cnt - CW'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_floor      <= '0;
      r_dir_up     <= 1'b0;
      r_moving     <= 1'b0;
      r_doors_open <= 1'b0;
      r_done       <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_floor      <= w_floor_nxt;
      r_dir_up     <= w_dir_up_nxt;
      r_moving     <= (w_state_nxt == S_MOVE);
      r_doors_open <= (w_state_nxt == S_DOOR);
      r_done       <= (w_state_nxt == S_FIN);
      r_fault      <= w_fault_nxt;
    end
  end

  assign cmd_ready  = (r_state == S_IDLE) & ~rst;
  assign cur_floor  = r_floor;
  assign moving     = r_moving;
  assign doors_open = r_doors_open;
  assign done       = r_done;
  assign fault      = r_fault;

endmodule

// File: tb/tb_elevator_car.sv
// Randomized scoreboard bench for elevator_car: a floor-level model predicts each command's
// outcome; a monitor checks it when done pulses. Honors `ELEV_CAR_DOOR_REOPEN_EN.
module tb_elevator_car;

  localparam int N = 4;
  localparam int T = 8;
  localparam int D = 6;
  localparam logic [1:0] C_IDLE = 2'd0, C_UP = 2'd1, C_DOWN = 2'd2, C_SERVE = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cmd;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       door_block;
  logic [1:0] cur_floor;
  logic       moving, doors_open, done, fault;

  elevator_car #(.N_FLOORS(N), .TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .door_block(door_block), .cur_floor(cur_floor), .moving(moving),
    .doors_open(doors_open), .done(done), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int fault;
    int floor;
    int mv;
    int dr;
  } exp_t;

  exp_t sb[$];
  int   m_floor = 0;
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // Behavioural model: floor-level outcome of one command; p = door cycle carrying a block pulse.
  function automatic exp_t model(input logic [1:0] c, input int p);
    exp_t e;
    e = '{fault: 0, floor: m_floor, mv: 0, dr: 0};
    case (c)
      C_UP:    if (m_floor < N - 1) begin m_floor++; e.mv = T; end else e.fault = 1;
      C_DOWN:  if (m_floor > 0)     begin m_floor--; e.mv = T; end else e.fault = 1;
      C_SERVE: begin
        e.dr = D;
`ifdef ELEV_CAR_DOOR_REOPEN_EN
        if (p > 0) e.dr = p + D;
`endif
      end
      default: ;
    endcase
    e.floor = m_floor;
    return e;
  endfunction

  task automatic issue(input logic [1:0] c, input int p);
    int waited = 0;
    @(negedge clk);
    while (!cmd_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    cmd       = c;
    cmd_valid = 1'b1;
    sb.push_back(model(c, p));
    @(negedge clk);
    cmd_valid = 1'b0;
    if (c == C_SERVE && p > 0) begin
      repeat (p - 1) @(negedge clk);
      door_block = 1'b1;
      @(negedge clk);
      door_block = 1'b0;
    end
  endtask

  // Monitor: accumulate motion/door cycles, compare against the scoreboard on each done.
  initial begin
    int   mv = 0;
    int   dr = 0;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        mv = 0;
        dr = 0;
      end else begin
        if (moving && doors_open) check("moving_and_doors_open", 1, 0);
        if (done && (moving || doors_open)) check("done_while_busy", 1, 0);
        if (fault && !done) check("fault_without_done", 1, 0);
        if (moving) mv++;
        if (doors_open) dr++;
        if (done) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            check("fault", int'(fault), e.fault);
            check("floor", int'(cur_floor), e.floor);
            check("moving_cycles", mv, e.mv);
            check("door_cycles", dr, e.dr);
          end
          mv = 0;
          dr = 0;
        end
      end
    end
  end

  initial begin
    int waited;
    logic [1:0] c;
    int p;
    rst        = 1'b1;
    cmd        = C_IDLE;
    cmd_valid  = 1'b0;
    door_block = 1'b0;

    // Reset held for three cycles
    repeat (3) begin
      @(negedge clk);
      check("rst_floor", int'(cur_floor), 0);
      check("rst_moving", int'(moving), 0);
      check("rst_doors", int'(doors_open), 0);
      check("rst_done", int'(done), 0);
      check("rst_fault", int'(fault), 0);
      check("rst_ready", int'(cmd_ready), 0);
    end
    rst = 1'b0;
    #1;
    check("ready_after_rst", int'(cmd_ready), 1);

    // Three UPs, then an illegal UP at the top
    repeat (3) issue(C_UP, 0);
    issue(C_UP, 0);
    // SERVE at floor 2
    issue(C_DOWN, 0);
    issue(C_SERVE, 0);

    // DOWN held during a move is ignored, then accepted when ready returns
    issue(C_UP, 0);
    cmd       = C_DOWN;
    cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("held_ready_low", int'(cmd_ready), 0);
    issue(C_DOWN, 0);

    // Reset in cycle 4 of a DOWN from floor 3
    issue(C_UP, 0);
    issue(C_DOWN, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    m_floor = 0;
    @(negedge clk);
    check("abort_floor", int'(cur_floor), 0);
    check("abort_moving", int'(moving), 0);
    check("abort_done", int'(done), 0);
    rst = 1'b0;
    #1;
    check("abort_ready", int'(cmd_ready), 1);

    // SERVE with a one-cycle block pulse in door cycle 4
    issue(C_SERVE, 4);
    // Illegal DOWN at floor 0 and an IDLE command
    issue(C_DOWN, 0);
    issue(C_IDLE, 0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      c = 2'($urandom_range(0, 3));
      p = (c == C_SERVE && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, D)) : 0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(c, p);
    end

    waited = 0;
    while (sb.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("drain_pending", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
